// File: rtl/player_mover_pkg.sv
// Shared types and constants for the player position updater.
// Build option: PLAYER_MOVER_NOCLIP_EN (see player_mover.sv).
package player_pkg;

    // Update sequencer states; one probe/wait pair per axis.
    typedef enum logic [2:0] {
        S_IDLE,
        S_X_PROBE,
        S_X_WAIT,
        S_Y_PROBE,
        S_Y_WAIT,
        S_FINISH
    } state_t;

    // Default geometry: 64 x 32 cell map, 8 fractional bits per cell.
    localparam int XC_BITS_DEF   = 6;
    localparam int YC_BITS_DEF   = 5;
    localparam int FRAC_BITS_DEF = 8;
    localparam int CELL_BITS_DEF = 3;

    // Fixed-point position widths for the default geometry.
    localparam int POS_X_W = XC_BITS_DEF + FRAC_BITS_DEF;
    localparam int POS_Y_W = YC_BITS_DEF + FRAC_BITS_DEF;

    // Map code for a walkable cell; every other code is a wall.
    localparam int CELL_EMPTY = 0;

endpackage

// File: rtl/player_mover_axis_step.sv
// One-axis movement proposal: candidate position one step along the
// requested direction, the map cell under the leading edge of the player,
// and whether either point falls outside the map.
module player_axis_step #(
    parameter int CELL_W    = 6,
    parameter int FRAC_BITS = 8,
    parameter int STEP      = 32,
    parameter int RADIUS    = 64,
    localparam int W        = CELL_W + FRAC_BITS
) (
    input  logic [W-1:0]      pos,
    input  logic              move,
    input  logic              neg,
    output logic [W-1:0]      cand,
    output logic [CELL_W-1:0] edge_cell,
    output logic              range_block
);

    // Two guard bits: one for the sign, one to catch overflow past the map.
    localparam logic signed [W+1:0] STEP_S   = (W+2)'(STEP);
    localparam logic signed [W+1:0] RADIUS_S = (W+2)'(RADIUS);

    logic signed [W+1:0] pos_s;
    logic signed [W+1:0] cand_s;
    logic signed [W+1:0] lead_s;

    // Candidate position and leading-edge position in signed arithmetic.
    always_comb begin
        pos_s  = $signed({2'b00, pos});
        cand_s = neg ? (pos_s - STEP_S) : (pos_s + STEP_S);
        lead_s = neg ? (cand_s - RADIUS_S) : (cand_s + RADIUS_S);
    end

    // Negative values set the sign bit; values >= 2^W set bit W.
    assign range_block = move & ((|cand_s[W+1:W]) | (|lead_s[W+1:W]));
    assign cand        = move ? cand_s[W-1:0] : pos;
    assign edge_cell   = lead_s[W-1:FRAC_BITS];

endmodule

// File: rtl/player_mover.sv
// Per-frame player position updater with wall collision.
// X is tried first, then Y against the already-updated X, so a blocked
// axis does not stop the other one and the player slides along walls.
// Build option: PLAYER_MOVER_NOCLIP_EN ignores the map contents; only the
// map bounds block movement. Sequencing and latency are identical.
module player_mover
    import player_pkg::*;
#(
    parameter int XC_BITS   = XC_BITS_DEF,
    parameter int YC_BITS   = YC_BITS_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int CELL_BITS = CELL_BITS_DEF,
    parameter int STEP      = 32,
    parameter int RADIUS    = 64,
    parameter int GRID_LAT  = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    output logic                         done,
    input  logic                         key_up,
    input  logic                         key_down,
    input  logic                         key_left,
    input  logic                         key_right,
    input  logic [XC_BITS+FRAC_BITS-1:0] player_x,
    input  logic [YC_BITS+FRAC_BITS-1:0] player_y,
    output logic [XC_BITS+FRAC_BITS-1:0] result_x,
    output logic [YC_BITS+FRAC_BITS-1:0] result_y,
    output logic [XC_BITS-1:0]           grid_x,
    output logic [YC_BITS-1:0]           grid_y,
    input  logic [CELL_BITS-1:0]         grid_out,
    output logic                         busy
);

    localparam int X_W = XC_BITS + FRAC_BITS;
    localparam int Y_W = YC_BITS + FRAC_BITS;
    localparam logic [1:0] WAIT_LOAD = 2'(GRID_LAT - 1);

    state_t         state;
    logic [X_W-1:0] work_x;
    logic [Y_W-1:0] work_y;
    logic           move_x, neg_x, move_y, neg_y;
    logic [1:0]     wait_cnt;

    // The X probe address is issued on the start edge itself, so X proposals
    // come straight from the ports while idle and from the working copy after.
    logic [X_W-1:0]     x_pos;
    logic               x_move, x_neg;
    logic [X_W-1:0]     x_cand;
    logic [XC_BITS-1:0] x_edge_cell;
    logic               x_range_block;
    logic [Y_W-1:0]     y_cand;
    logic [YC_BITS-1:0] y_edge_cell;
    logic               y_range_block;

    assign x_pos  = (state == S_IDLE) ? player_x : work_x;
    assign x_move = (state == S_IDLE) ? (key_left ^ key_right) : move_x;
    assign x_neg  = (state == S_IDLE) ? key_left : neg_x;

    player_axis_step #(
        .CELL_W   (XC_BITS),
        .FRAC_BITS(FRAC_BITS),
        .STEP     (STEP),
        .RADIUS   (RADIUS)
    ) u_x_step (
        .pos        (x_pos),
        .move       (x_move),
        .neg        (x_neg),
        .cand       (x_cand),
        .edge_cell  (x_edge_cell),
        .range_block(x_range_block)
    );

    player_axis_step #(
        .CELL_W   (YC_BITS),
        .FRAC_BITS(FRAC_BITS),
        .STEP     (STEP),
        .RADIUS   (RADIUS)
    ) u_y_step (
        .pos        (work_y),
        .move       (move_y),
        .neg        (neg_y),
        .cand       (y_cand),
        .edge_cell  (y_edge_cell),
        .range_block(y_range_block)
    );

    logic wall;
`ifdef PLAYER_MOVER_NOCLIP_EN
    assign wall = 1'b0;
`else
    assign wall = (grid_out != CELL_BITS'(CELL_EMPTY));
`endif

    // Axis decisions, meaningful only in the last wait cycle of each axis.
    logic           x_accept, y_accept;
    logic [X_W-1:0] x_next;
    logic [Y_W-1:0] y_next;

    assign x_accept = move_x & ~x_range_block & ~wall;
    assign y_accept = move_y & ~y_range_block & ~wall;
    assign x_next   = x_accept ? x_cand : work_x;
    assign y_next   = y_accept ? y_cand : work_y;

    // Update sequencer: probe X, wait for the map, probe Y, wait, publish.
    // NOTE: every register here uses <= so all of them see pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            done     <= 1'b0;
            busy     <= 1'b0;
            result_x <= '0;
            result_y <= '0;
            grid_x   <= '0;
            grid_y   <= '0;
            work_x   <= '0;
            work_y   <= '0;
            move_x   <= 1'b0;
            neg_x    <= 1'b0;
            move_y   <= 1'b0;
            neg_y    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        work_x <= player_x;
                        work_y <= player_y;
                        move_x <= key_left ^ key_right;
                        neg_x  <= key_left;
                        move_y <= key_up ^ key_down;
                        neg_y  <= key_up;
                        // Out-of-map proposals never touch the grid port.
                        if (x_move && !x_range_block) begin
                            grid_x <= x_edge_cell;
                            grid_y <= player_y[Y_W-1:FRAC_BITS];
                        end
                        busy  <= 1'b1;
                        state <= S_X_PROBE;
                    end
                end
                S_X_PROBE: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= S_X_WAIT;
                end
                S_X_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        work_x <= x_next;
                        // Y probes the column the player ends up in after X.
                        if (move_y && !y_range_block) begin
                            grid_x <= x_next[X_W-1:FRAC_BITS];
                            grid_y <= y_edge_cell;
                        end
                        state <= S_Y_PROBE;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                S_Y_PROBE: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= S_Y_WAIT;
                end
                S_Y_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        work_y   <= y_next;
                        result_x <= work_x;
                        result_y <= y_next;
                        done     <= 1'b1;
                        state    <= S_FINISH;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_mover.sv
// Self-checking bench for player_mover: directed scenarios plus randomized
// updates against a map/arithmetic reference model.
module tb_player_mover;

    localparam int XC      = 6;
    localparam int YC      = 5;
    localparam int FR      = 8;
    localparam int CB      = 3;
    localparam int STEP    = 32;
    localparam int RADIUS  = 64;
    localparam int LAT     = 1;
    localparam int XW      = XC + FR;
    localparam int YW      = YC + FR;
    localparam int EXP_LAT = 2 * (LAT + 1) + 1;
`ifdef PLAYER_MOVER_NOCLIP_EN
    localparam bit NOCLIP = 1'b1;
`else
    localparam bit NOCLIP = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          done, busy;
    logic          key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
    logic [XW-1:0] player_x = '0;
    logic [YW-1:0] player_y = '0;
    logic [XW-1:0] result_x;
    logic [YW-1:0] result_y;
    logic [XC-1:0] grid_x;
    logic [YC-1:0] grid_y;
    logic [CB-1:0] grid_out;

    logic [CB-1:0] map_mem [64][32];
    logic [CB-1:0] pipe [LAT];

    int n_cmp  = 0;
    int n_bad  = 0;
    int exp_gx = 0;
    int exp_gy = 0;

    player_mover #(
        .XC_BITS(XC), .YC_BITS(YC), .FRAC_BITS(FR), .CELL_BITS(CB),
        .STEP(STEP), .RADIUS(RADIUS), .GRID_LAT(LAT)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .done(done),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .player_x(player_x), .player_y(player_y),
        .result_x(result_x), .result_y(result_y),
        .grid_x(grid_x), .grid_y(grid_y), .grid_out(grid_out), .busy(busy)
    );

    always #5 clock = ~clock;

    // Map ROM with GRID_LAT cycles of read latency.
    always @(posedge clock) begin
        pipe[0] <= map_mem[grid_x][grid_y];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign grid_out = pipe[LAT-1];

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_map();
        for (int i = 0; i < 64; i++)
            for (int j = 0; j < 32; j++) map_mem[i][j] = '0;
    endtask

    task automatic random_map();
        for (int i = 0; i < 64; i++)
            for (int j = 0; j < 32; j++)
                map_mem[i][j] = ($urandom_range(0, 3) == 0) ? CB'($urandom_range(1, 7)) : '0;
    endtask

    // Reference: move X, then Y from the new X; a move is taken only if the
    // new point and its leading edge stay on the map and the edge cell is empty.
    // Keys k = {up, down, left, right}. Tracks the last probed grid cell.
    task automatic model(input int x, input int y, input logic [3:0] k,
                         output int ex, output int ey);
        int dx, dy, c, e, cx, cy;
        dx = int'(k[0]) - int'(k[1]);
        dy = int'(k[2]) - int'(k[3]);
        ex = x;
        ey = y;
        if (dx != 0) begin
            c = ex + dx * STEP;
            e = c + dx * RADIUS;
            if (c >= 0 && c < (1 << XW) && e >= 0 && e < (1 << XW)) begin
                cx = e >> FR;
                cy = ey >> FR;
                exp_gx = cx;
                exp_gy = cy;
                if (NOCLIP || map_mem[cx][cy] == 0) ex = c;
            end
        end
        if (dy != 0) begin
            c = ey + dy * STEP;
            e = c + dy * RADIUS;
            if (c >= 0 && c < (1 << YW) && e >= 0 && e < (1 << YW)) begin
                cx = ex >> FR;
                cy = e >> FR;
                exp_gx = cx;
                exp_gy = cy;
                if (NOCLIP || map_mem[cx][cy] == 0) ey = c;
            end
        end
    endtask

    // Called at a negedge: present one request.
    task automatic drive_start(input int x, input int y, input logic [3:0] k);
        start    = 1'b1;
        player_x = XW'(x);
        player_y = YW'(y);
        {key_up, key_down, key_left, key_right} = k;
    endtask

    // Accept edge, then scramble inputs (they must be ignored), wait for done,
    // check latency and results; optionally raise the next start during FINISH.
    task automatic finish_update(input string tag, input int ex, input int ey,
                                 input bit nx_en, input int nx, input int ny,
                                 input logic [3:0] nk);
        int cyc;
        bit seen;
        @(posedge clock);
        #1;
        start    = 1'b0;
        player_x = XW'($urandom);
        player_y = YW'($urandom);
        {key_up, key_down, key_left, key_right} = 4'($urandom);
        seen = 1'b0;
        cyc  = 0;
        for (int i = 1; i <= 30 && !seen; i++) begin
            @(negedge clock);
            cyc = i;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            check({tag, "_done_timeout"}, 0, 1);
            return;
        end
        check({tag, "_latency"}, cyc, EXP_LAT);
        check({tag, "_result_x"}, result_x, ex);
        check({tag, "_result_y"}, result_y, ey);
        check({tag, "_grid_x"}, grid_x, exp_gx);
        check({tag, "_grid_y"}, grid_y, exp_gy);
        check({tag, "_busy_finish"}, busy, 1);
        if (nx_en) drive_start(nx, ny, nk);
        @(negedge clock);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_idle"}, busy, 0);
    endtask

    task automatic gen(output int x, output int y, output logic [3:0] k);
        case ($urandom_range(0, 3))
            0:       begin x = $urandom_range(0, 120);              y = $urandom_range(0, 120); end
            1:       begin x = (1 << XW) - 1 - $urandom_range(0, 120); y = (1 << YW) - 1 - $urandom_range(0, 120); end
            default: begin x = $urandom_range(0, (1 << XW) - 1);    y = $urandom_range(0, (1 << YW) - 1); end
        endcase
        k = 4'($urandom);
    endtask

    initial begin
        int ex, ey, x, y, nx, ny, hits;
        logic [3:0] k, nk;
        bit b2b;

        clear_map();
        for (int i = 0; i < LAT; i++) pipe[i] = '0;

        // Reset state.
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_result_x", result_x, 0);
        check("rst_result_y", result_y, 0);
        check("rst_grid_x", grid_x, 0);
        check("rst_grid_y", grid_y, 0);

        // Open field, move right.
        drive_start('h1080, 'h0880, 4'b0001);
        model('h1080, 'h0880, 4'b0001, ex, ey);
        finish_update("open", ex, ey, 1'b0, 0, 0, 4'b0);
        check("open_x_value", result_x, 'h10A0);
        check("open_y_value", result_y, 'h0880);

        // Wall to the right at (17,8).
        map_mem[17][8] = 3'd3;
        drive_start('h10C0, 'h0880, 4'b0001);
        model('h10C0, 'h0880, 4'b0001, ex, ey);
        finish_update("wall", ex, ey, 1'b0, 0, 0, 4'b0);
        check("wall_x_value", result_x, NOCLIP ? 'h10E0 : 'h10C0);

        // Slide: right blocked, down free.
        drive_start('h10C0, 'h0880, 4'b0101);
        model('h10C0, 'h0880, 4'b0101, ex, ey);
        finish_update("slide", ex, ey, 1'b0, 0, 0, 4'b0);
        check("slide_y_value", result_y, 'h08A0);

        // Left edge of the map, then opposing keys; the second start is
        // raised during FINISH of the first and must wait for IDLE.
        drive_start('h0010, 'h0880, 4'b0010);
        model('h0010, 'h0880, 4'b0010, ex, ey);
        finish_update("bound", ex, ey, 1'b1, 'h1080, 'h0880, 4'b0011);
        check("bound_x_value", result_x, 'h0010);
        model('h1080, 'h0880, 4'b0011, ex, ey);
        finish_update("both_keys", ex, ey, 1'b0, 0, 0, 4'b0);
        check("both_keys_x_value", result_x, 'h1080);

        // Reset in the middle of an update.
        drive_start('h1080, 'h0880, 4'b0001);
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_gx = 0;
        exp_gy = 0;
        check("midrst_done", done, 0);
        check("midrst_busy", busy, 0);
        check("midrst_result_x", result_x, 0);
        check("midrst_result_y", result_y, 0);
        hits = 0;
        repeat (8) begin
            @(negedge clock);
            if (done) hits++;
        end
        check("midrst_no_done", hits, 0);
        drive_start('h2000, 'h0400, 4'b1000);
        model('h2000, 'h0400, 4'b1000, ex, ey);
        finish_update("after_rst", ex, ey, 1'b0, 0, 0, 4'b0);

        // Randomized updates over random maps.
        random_map();
        gen(x, y, k);
        drive_start(x, y, k);
        for (int i = 0; i < 300; i++) begin
            model(x, y, k, ex, ey);
            b2b = (i < 299) && ($urandom_range(0, 3) == 0);
            gen(nx, ny, nk);
            finish_update("rnd", ex, ey, b2b, nx, ny, nk);
            if (!b2b && i < 299) begin
                if (i % 50 == 49) random_map();
                drive_start(nx, ny, nk);
            end
            x = nx;
            y = ny;
            k = nk;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
